mem_arbiter: RTL and testbench

//  Shares the single unified memory port of the multi-cycle MIPS system between two requesters:
//  m0 = processor (adr/writedata/memwrite/readdata) and m1 = program loader / DMA.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin arbiter sharing one variable-latency memory port
//           between two req/ack requesters, with a wait-state timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;     // 1 = m1 was granted last
    logic          owner_q, owner_d;   // 1 = m1 owns the current transaction
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          w_gnt1;
    logic [DW-1:0] w_result;

    // On a tie the requester that was not served last wins.
    assign w_gnt1   = m1_req & (~m0_req | ~last_q);
    assign w_result = we_q ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = w_gnt1;
                    we_d    = w_gnt1 ? m1_we    : m0_we;
                    adr_d   = w_gnt1 ? m1_adr   : m0_adr;
                    wdata_d = w_gnt1 ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                // A ready in the last allowed cycle still counts as success.
                if (mem_ready) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (owner_q) rdata1_d = w_result;
                    else         rdata0_d = w_result;
                end else if (cnt_q == c_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                    if (owner_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;

    assign m0_ack    = (state_q == S_RESP) & ~owner_q;
    assign m1_ack    = (state_q == S_RESP) &  owner_q;
    assign m0_err    = m0_ack & err_q;
    assign m1_err    = m1_ack & err_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter with an ack scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input int max_cycles);
        int   n = 0;
        exp_t e;
        while (!(m0_ack || m1_ack) && n < max_cycles) begin
            step();
            n++;
        end
        if (!(m0_ack || m1_ack)) begin
            chk("ack_timeout", 64'd0, 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_empty_on_ack", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("ack_who", {63'd0, m1_ack}, {63'd0, e.who});
        chk("ack_excl", {63'd0, m0_ack & m1_ack}, 64'd0);
        chk("ack_err", {63'd0, e.who ? m1_err : m0_err}, {63'd0, e.err});
        chk("ack_rdata", {32'd0, e.who ? m1_rdata : m0_rdata}, {32'd0, e.rdata});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, {63'd0, mem_en}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_adr"}, {32'd0, mem_adr}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_acks"}, {62'd0, m0_ack, m1_ack}, 64'd0);
        chk({tag, "_errs"}, {62'd0, m0_err, m1_err}, 64'd0);
        chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adr = 32'h0;  m1_wdata = 32'h0;

        // Reset held with a pending m0 request
        step(); step();
        chk_all_zero("rst");

        // m0 zero-wait-state read
        sb.push_back('{who: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF});
        reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("rd0_mem_en", {63'd0, mem_en}, 64'd1);
        chk("rd0_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rd0_mem_adr", {32'd0, mem_adr}, 64'h40);
        step();
        chk("rd0_mem_en_off", {63'd0, mem_en}, 64'd0);
        expect_ack(0);
        m0_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("rd0_ack_pulse", {63'd0, m0_ack}, 64'd0);
        chk("rd0_rdata_held", {32'd0, m0_rdata}, 64'hDEADBEEF);
        mem_ready = 1'b1;
        step();
        chk("idle_ready_ignored", {62'd0, m0_ack, m1_ack}, 64'd0);
        mem_ready = 1'b0;

        // Continuous requests alternate; m0 was served last so m1 goes first
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h44; m0_wdata = 32'hAAAA;
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h80; m1_wdata = 32'h1234;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic is_m1;
            is_m1     = (k % 2 == 0);
            mem_rdata = 32'h11110000 + k;
            sb.push_back('{who: is_m1, err: 1'b0, rdata: is_m1 ? 32'h0 : 32'h11110000 + k});
            step();
            chk("rr_mem_en", {63'd0, mem_en}, 64'd1);
            chk("rr_mem_we", {63'd0, mem_we}, {63'd0, is_m1});
            chk("rr_mem_adr", {32'd0, mem_adr}, is_m1 ? 64'h80 : 64'h44);
            if (is_m1) chk("rr_mem_wdata", {32'd0, mem_wdata}, 64'h1234);
            step();
            expect_ack(0);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        step();

        // m1 read with ready arriving in the third ACCESS cycle
        m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h90; mem_rdata = 32'hCAFEF00D;
        sb.push_back('{who: 1'b1, err: 1'b0, rdata: 32'hCAFEF00D});
        for (int c = 0; c < 3; c++) begin
            step();
            chk("ws_mem_en", {63'd0, mem_en}, 64'd1);
            chk("ws_mem_adr", {32'd0, mem_adr}, 64'h90);
            chk("ws_no_ack", {62'd0, m0_ack, m1_ack}, 64'd0);
            m1_adr = 32'hFFF0;
            if (c == 2) mem_ready = 1'b1;
        end
        step();
        chk("ws_mem_en_off", {63'd0, mem_en}, 64'd0);
        chk("ws_m0_ack", {63'd0, m0_ack}, 64'd0);
        expect_ack(0);
        m1_req = 1'b0; mem_ready = 1'b0;
        step();

        // m0 read that never sees ready: timeout after 4 ACCESS cycles
        m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h48; mem_rdata = 32'h55555555;
        sb.push_back('{who: 1'b0, err: 1'b1, rdata: 32'h0});
        for (int c = 0; c < 4; c++) begin
            step();
            chk("to_mem_en", {63'd0, mem_en}, 64'd1);
            chk("to_no_ack", {63'd0, m0_ack}, 64'd0);
        end
        step();
        chk("to_mem_en_off", {63'd0, mem_en}, 64'd0);
        expect_ack(0);
        m0_req = 1'b0;
        step();
        chk("to_idle_en", {63'd0, mem_en}, 64'd0);
        chk("to_idle_ack", {63'd0, m0_ack}, 64'd0);

        // Ready in the final allowed cycle wins over timeout
        m0_req = 1'b1; mem_rdata = 32'h77778888;
        sb.push_back('{who: 1'b0, err: 1'b0, rdata: 32'h77778888});
        for (int c = 0; c < 4; c++) begin
            step();
            chk("late_mem_en", {63'd0, mem_en}, 64'd1);
            if (c == 3) mem_ready = 1'b1;
        end
        step();
        expect_ack(0);
        m0_req = 1'b0; mem_ready = 1'b0;
        step();

        // Reset during m1's ACCESS abandons it; tie then goes to m0
        m0_req = 1'b1; m0_adr = 32'h4C; m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h84;
        step();
        chk("ab_m1_owner", {32'd0, mem_adr}, 64'h84);
        reset = 1'b0;
        step();
        chk_all_zero("ab_rst");
        reset = 1'b1;
        step();
        chk("ab_tie_m0", {32'd0, mem_adr}, 64'h4C);
        chk("ab_tie_en", {63'd0, mem_en}, 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        sb.push_back('{who: 1'b0, err: 1'b0, rdata: 32'h0BADF00D});
        step();
        chk("ab_m1_ack", {63'd0, m1_ack}, 64'd0);
        expect_ack(0);
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
        step();

        chk("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
